// File: rtl/matmul_feeder_pkg.sv
// Shared types and constants for the matmul input feeder.
// Provides: feeder_state_t (FSM states) and LANE_W, which is the full
// input-vector width for the default word size.
`include "header_ws.vh"

package matmul_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } feeder_state_t;

  localparam int WORD_SIZE_DEF = 16;
  localparam int LANE_W        = `ROWS * WORD_SIZE_DEF;

endpackage

// File: rtl/header_ws.vh
// Array geometry shared by the weight-stationary matmul path.
// ROWS : number of array rows, which is also the number of feeder lanes.
`ifndef HEADER_WS_VH
`define HEADER_WS_VH
`define ROWS 4
`endif

// File: rtl/matmul_input_feeder_skew.sv
// skew_delay_line: fixed-depth shift register that delays one lane of the
// feeder output, including the lane's valid bit.
// Ports: clk, clr (synchronous clear of all stages), din, dout (din delayed
// by DEPTH cycles).
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/matmul_input_feeder.sv
// matmul_input_feeder: buffers activation vectors in a FIFO and, on start,
// issues vec_count of them into the systolic array's left edge. Each vector
// is held for ISSUE_INTERVAL cycles, and lane r is skewed by r cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input vector handshake, in_vec = ROWS words
//   start, vec_count    run request and run length (sampled together)
//   busy, done          run in progress / end-of-run pulse
//   act_out, act_valid  skewed per-row word and valid
//   bubble_cnt          bubble slots in the current run (only with
//                       INPUT_FEEDER_BUBBLE_CNT_EN defined)
//
// State | meaning
// IDLE  | waiting for start; a zero-length run only pulses done
// RUN   | issuing slots; a slot with an empty FIFO is an uncounted bubble
// DRAIN | ROWS-1 cycles letting the skew lines empty before done
`include "header_ws.vh"

module matmul_input_feeder
  import matmul_feeder_pkg::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int DEPTH          = 8,
  parameter int ISSUE_INTERVAL = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`ROWS*WORD_SIZE-1:0]  in_vec,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        vec_count,
  output logic                        busy,
  output logic                        done,
  output logic [`ROWS*WORD_SIZE-1:0]  act_out,
  output logic [`ROWS-1:0]            act_valid
`ifdef INPUT_FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]                 bubble_cnt
`endif
);

  localparam int LW = `ROWS * WORD_SIZE;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam int DW = $clog2(`ROWS) + 1;

  // FIFO
  logic [LW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, empty, push, pop;

  // full is taken from pre-pop occupancy, so a full FIFO refuses a push
  // even in a cycle where it is also popped.
  assign full     = (occ == (AW+1)'(DEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (!push && pop) occ <= occ - 1'b1;
    end
  end

  // Control
  feeder_state_t        state, state_nxt;
  logic [CNT_WIDTH-1:0] remaining, rem_nxt;
  logic [SW-1:0]        slot_cnt, slot_nxt;
  logic [DW-1:0]        drain_cnt, drain_nxt;
  logic [LW-1:0]        issue_vec, issue_vec_nxt;
  logic                 issue_valid, issue_valid_nxt;
  logic                 zero_pend, zero_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      slot_cnt    <= '0;
      drain_cnt   <= '0;
      issue_vec   <= '0;
      issue_valid <= 1'b0;
      zero_pend   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= rem_nxt;
      slot_cnt    <= slot_nxt;
      drain_cnt   <= drain_nxt;
      issue_vec   <= issue_vec_nxt;
      issue_valid <= issue_valid_nxt;
      zero_pend   <= zero_nxt;
      done        <= done_nxt;
      // One cycle behind the state so busy covers the done cycle.
      busy        <= (state != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt       = state;
    rem_nxt         = remaining;
    slot_nxt        = slot_cnt;
    drain_nxt       = drain_cnt;
    issue_vec_nxt   = issue_vec;
    issue_valid_nxt = issue_valid;
    zero_nxt        = 1'b0;
    done_nxt        = zero_pend;
    pop             = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          rem_nxt  = vec_count;
          slot_nxt = '0;
          if (vec_count == '0) zero_nxt  = 1'b1;
          else                 state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (slot_cnt == '0) begin
          if (remaining == '0) begin
            issue_vec_nxt   = '0;
            issue_valid_nxt = 1'b0;
            if (`ROWS == 1) begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              drain_nxt = DW'(`ROWS - 1);
              state_nxt = ST_DRAIN;
            end
          end else begin
            slot_nxt = SW'(ISSUE_INTERVAL - 1);
            if (!empty) begin
              pop             = 1'b1;
              issue_vec_nxt   = mem[rd_ptr];
              issue_valid_nxt = 1'b1;
              rem_nxt         = remaining - 1'b1;
            end else begin
              issue_vec_nxt   = '0;
              issue_valid_nxt = 1'b0;
            end
          end
        end else begin
          slot_nxt = slot_cnt - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DW'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          drain_nxt = drain_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef INPUT_FEEDER_BUBBLE_CNT_EN
  logic bubble_slot, run_start;

  assign bubble_slot = (state == ST_RUN) && (slot_cnt == '0) &&
                       (remaining != '0) && empty;
  assign run_start   = (state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst || run_start)                       bubble_cnt <= '0;
    else if (bubble_slot && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 1'b1;
  end
`endif

  // Skew: lane 0 is the issue register itself; lane r adds r stages.
  assign act_out[WORD_SIZE-1:0] = issue_vec[WORD_SIZE-1:0];
  assign act_valid[0]           = issue_valid;

  for (genvar r = 1; r < `ROWS; r++) begin : g_lane
    logic [WORD_SIZE:0] dly_out;

    skew_delay_line #(
      .DEPTH(r),
      .WIDTH(WORD_SIZE + 1)
    ) u_dly (
      .clk  (clk),
      .clr  (rst),
      .din  ({issue_valid, issue_vec[r*WORD_SIZE +: WORD_SIZE]}),
      .dout (dly_out)
    );

    assign act_out[r*WORD_SIZE +: WORD_SIZE] = dly_out[WORD_SIZE-1:0];
    assign act_valid[r]                      = dly_out[WORD_SIZE];
  end

endmodule

// File: tb/tb_matmul_input_feeder.sv
// Directed self-checking bench for matmul_input_feeder.
// Vector v carries word r = r + 10*v on row r.
`ifndef ROWS
`include "header_ws.vh"
`endif

module tb_matmul_input_feeder;

  localparam int ROWS = `ROWS;
  localparam int WS   = 16;
  localparam int DEP  = 8;
  localparam int II   = 2;
  localparam int CW   = 8;
  localparam int LW   = ROWS * WS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [LW-1:0]  in_vec;
  logic           start;
  logic [CW-1:0]  vec_count;
  logic           busy;
  logic           done;
  logic [LW-1:0]  act_out;
  logic [ROWS-1:0] act_valid;
`ifdef INPUT_FEEDER_BUBBLE_CNT_EN
  logic [15:0]    bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  matmul_input_feeder #(
    .WORD_SIZE(WS), .DEPTH(DEP), .ISSUE_INTERVAL(II), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .start(start), .vec_count(vec_count),
    .busy(busy), .done(done), .act_out(act_out), .act_valid(act_valid)
`ifdef INPUT_FEEDER_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk(input int v);
    logic [LW-1:0] x;
    x = '0;
    for (int r = 0; r < ROWS; r++) x[r*WS +: WS] = WS'(r + 10*v);
    return x;
  endfunction

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_vec   = mk(base + i);
      while (!in_ready && guard < 100) begin step(); guard++; end
      if (guard >= 100) chk("preload_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Full-run check: lane r carries vector (base + k/II) for k = t-r-1 in
  // [0, n*II); done at t = n*II+ROWS; busy over t = 1..n*II+ROWS.
  // spur >= 0 pulses an extra start (count 5) in that cycle of the run.
  task automatic run_check(input int n, input int base, input int spur);
    int last;
    last = n*II + ROWS;
    vec_count = CW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    vec_count = '0;
    for (int t = 0; t <= last + 1; t++) begin
      if (t > 0) step();
      chk($sformatf("busy_b%0d_t%0d", base, t), busy, (t >= 1 && t <= last));
      chk($sformatf("done_b%0d_t%0d", base, t), done, (t == last));
      for (int r = 0; r < ROWS; r++) begin
        int k;
        logic ev;
        logic [WS-1:0] ed;
        k  = t - r - 1;
        ev = (k >= 0 && k < n*II);
        ed = ev ? WS'(r + 10*(base + k/II)) : '0;
        chk($sformatf("lane%0d_b%0d_t%0d", r, base, t),
            {act_valid[r], act_out[r*WS +: WS]}, {ev, ed});
      end
      if (t == spur) begin
        start = 1'b1;
        vec_count = CW'(5);
      end else begin
        start = 1'b0;
        vec_count = '0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; start = 1'b0; vec_count = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_act_out", act_out, 0);
    chk("rst_act_valid", act_valid, 0);
`ifdef INPUT_FEEDER_BUBBLE_CNT_EN
    chk("rst_bubble_cnt", bubble_cnt, 0);
`endif

    // basic run: 3 vectors
    preload(0, 3);
    run_check(3, 0, -1);

    // zero count: done one cycle later, busy never rises
    vec_count = '0; start = 1'b1; step(); start = 1'b0;
    chk("zc_done_T", done, 0);
    chk("zc_busy_T", busy, 0);
    step();
    chk("zc_done_T1", done, 1);
    chk("zc_busy_T1", busy, 0);
    step();
    chk("zc_done_T2", done, 0);
    chk("zc_busy_T2", busy, 0);

    // start during RUN is ignored
    preload(10, 3);
    run_check(3, 10, 2);

    // back-pressure
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_vec = mk(60 + k);
      chk($sformatf("bp_ready%0d", k), in_ready, 1);
      step();
    end
    in_vec = mk(68);
    chk("bp_full", in_ready, 0);
    vec_count = CW'(1); start = 1'b1; step(); start = 1'b0; vec_count = '0;
    chk("bp_full_T", in_ready, 0);
    step();
    chk("bp_reopen", in_ready, 1);
    chk("bp_lane0", {act_valid[0], act_out[WS-1:0]}, {1'b1, 16'd600});
    step();
    in_valid = 1'b0;
    chk("bp_full_again", in_ready, 0);
    guard = 0;
    while (!done && guard < 50) begin step(); guard++; end
    chk("bp_done", done, 1);
    step();
    run_check(8, 61, -1);

    // bubble insertion: empty FIFO, pushes land at T+3 and T+8
    vec_count = CW'(2); start = 1'b1; step(); start = 1'b0; vec_count = '0;
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) step();
      chk($sformatf("bub_busy_t%0d", t), busy, (t >= 1 && t <= 14));
      chk($sformatf("bub_done_t%0d", t), done, (t == 14));
      for (int r = 0; r < ROWS; r++) begin
        int k;
        logic ev;
        logic [WS-1:0] ed;
        k  = t - r;
        ev = (k == 5 || k == 6 || k == 9 || k == 10);
        ed = ev ? WS'(r + 10*((k <= 6) ? 70 : 71)) : '0;
        chk($sformatf("bub_lane%0d_t%0d", r, t),
            {act_valid[r], act_out[r*WS +: WS]}, {ev, ed});
      end
      in_valid = (t == 2 || t == 7);
      in_vec   = (t == 2) ? mk(70) : mk(71);
    end
    in_valid = 1'b0;
`ifdef INPUT_FEEDER_BUBBLE_CNT_EN
    chk("bub_cnt", bubble_cnt, 3);
`endif

    // reset mid-run
    preload(80, 4);
    vec_count = CW'(4); start = 1'b1; step(); start = 1'b0; vec_count = '0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_act_valid", act_valid, 0);
    chk("mrst_act_out", act_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_done", done, 0);
    for (int t = 0; t < 12; t++) begin
      step();
      chk($sformatf("mrst_nodone_t%0d", t), done, 0);
    end
    preload(90, 1);
    run_check(1, 90, -1);

    // wrap-around: 20 vectors, three back-to-back runs
    preload(20, 7);
    run_check(7, 20, -1);
    preload(27, 7);
    run_check(7, 27, -1);
    preload(34, 6);
    run_check(6, 34, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
